// File: rtl/text_console.sv
// Character-cell text console: turns a stream of character/control codes into
// video RAM writes, with cursor tracking, backspace, full clear and one-row scroll.
module text_console #(
  parameter int          COLS  = 32,
  parameter int          ROWS  = 16,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic        wr_ram1,
  output logic        rd_ram1,
  output logic [10:0] addr,
  output logic [7:0]  data,
  input  logic [7:0]  ram1_out,
  output logic [3:0]  cursor_row,
  output logic [4:0]  cursor_col
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] PUT        = 3'd1;
  localparam logic [2:0] SCROLL_RD  = 3'd2;
  localparam logic [2:0] SCROLL_WR  = 3'd3;
  localparam logic [2:0] SCROLL_CLR = 3'd4;
  localparam logic [2:0] CLEAR      = 3'd5;

  localparam logic [10:0] COLS_A    = 11'(COLS);
  localparam logic [10:0] LAST_CELL = 11'(COLS * ROWS - 1);
  localparam logic [10:0] LAST_COPY = 11'((ROWS - 1) * COLS - 1);
  localparam logic [3:0]  LAST_ROW  = 4'(ROWS - 1);
  localparam logic [4:0]  LAST_COL  = 5'(COLS - 1);

  logic [2:0]  state;
  logic        run;
  logic [10:0] cnt;
  logic [3:0]  row;
  logic [4:0]  col;
  logic        put_adv;
  logic [7:0]  put_char;
  logic [10:0] cur_addr;
  logic        accept;

  assign char_ready = run && (state == IDLE);
  assign accept     = char_ready && char_valid;
  assign cur_addr   = 11'(row) * COLS_A + 11'(col);
  assign cursor_row = row;
  assign cursor_col = col;

  // run stays low for one cycle after release so no strobe is issued while
  // the state register already sits in CLEAR during reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= CLEAR;
      run     <= 1'b0;
      cnt     <= '0;
      row     <= '0;
      col     <= '0;
      put_adv <= 1'b0;
    end else if (!run) begin
      run <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (char_valid) begin
            case (char_data)
              8'h0C: begin
                state <= CLEAR;
                cnt   <= '0;
              end
              8'h0D: begin
                col <= '0;
                if (row != LAST_ROW) begin
                  row <= row + 4'd1;
                end else begin
                  state <= SCROLL_RD;
                  cnt   <= '0;
                end
              end
              8'h08: begin
                if (col != '0) begin
                  col     <= col - 5'd1;
                  put_adv <= 1'b0;
                  state   <= PUT;
                end else if (row != '0) begin
                  row     <= row - 4'd1;
                  col     <= LAST_COL;
                  put_adv <= 1'b0;
                  state   <= PUT;
                end
              end
              default: begin
                put_adv <= 1'b1;
                state   <= PUT;
              end
            endcase
          end
        end
        PUT: begin
          state <= IDLE;
          if (put_adv) begin
            if (col == LAST_COL) begin
              col <= '0;
              if (row != LAST_ROW) begin
                row <= row + 4'd1;
              end else begin
                state <= SCROLL_RD;
                cnt   <= '0;
              end
            end else begin
              col <= col + 5'd1;
            end
          end
        end
        SCROLL_RD: state <= SCROLL_WR;
        SCROLL_WR: begin
          cnt   <= cnt + 11'd1;
          state <= (cnt == LAST_COPY) ? SCROLL_CLR : SCROLL_RD;
        end
        SCROLL_CLR: begin
          cnt <= cnt + 11'd1;
          if (cnt == LAST_CELL) state <= IDLE;
        end
        CLEAR: begin
          cnt <= cnt + 11'd1;
          if (cnt == LAST_CELL) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Backspace reuses PUT to write a blank at the already-moved cursor.
  always_ff @(posedge clk) begin
    if (accept) put_char <= (char_data == 8'h08) ? BLANK : char_data;
  end

  always_comb begin
    wr_ram1 = 1'b0;
    rd_ram1 = 1'b0;
    addr    = cur_addr;
    data    = 8'h00;
    if (run) begin
      case (state)
        PUT: begin
          wr_ram1 = 1'b1;
          data    = put_char;
        end
        SCROLL_RD: begin
          rd_ram1 = 1'b1;
          addr    = cnt + COLS_A;
        end
        SCROLL_WR: begin
          wr_ram1 = 1'b1;
          addr    = cnt;
          data    = ram1_out;
        end
        SCROLL_CLR, CLEAR: begin
          wr_ram1 = 1'b1;
          addr    = cnt;
          data    = BLANK;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: screen-level reference model (array of cells plus a
// cursor) against a clocked video RAM model driven by the DUT strobes.
module tb_text_console;
  localparam int COLS  = 32;
  localparam int ROWS  = 16;
  localparam int CELLS = COLS * ROWS;
  localparam logic [7:0] BLANK = 8'h20;

  logic        clk = 1'b0;
  logic        resetn;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        wr_ram1;
  logic        rd_ram1;
  logic [10:0] addr;
  logic [7:0]  data;
  logic [7:0]  ram1_out;
  logic [3:0]  cursor_row;
  logic [4:0]  cursor_col;

  always #5 clk = ~clk;

  text_console #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
    .clk(clk), .resetn(resetn), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .wr_ram1(wr_ram1), .rd_ram1(rd_ram1), .addr(addr),
    .data(data), .ram1_out(ram1_out), .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  // Video RAM with one-cycle read latency; preload_mode 1 fills 8'hFF, 2 fills i[7:0].
  logic [7:0] mem [0:2047];
  logic [1:0] preload_mode;
  int n_wr = 0, n_rd = 0, n_ovl = 0;
  int wq[$];

  always @(posedge clk) begin
    if (preload_mode == 2'd1) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'hFF;
    end else if (preload_mode == 2'd2) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'(i);
    end else if (wr_ram1) begin
      mem[addr] <= data;
    end
    if (rd_ram1) ram1_out <= mem[addr];
    if (wr_ram1) begin
      n_wr <= n_wr + 1;
      wq.push_back(int'(addr));
    end
    if (rd_ram1) n_rd <= n_rd + 1;
    if ((wr_ram1 && rd_ram1) || (char_ready && (wr_ram1 || rd_ram1))) n_ovl <= n_ovl + 1;
  end

  int n_tests = 0, n_fail = 0;
  logic [7:0] em [0:CELLS-1];
  int er = 0, ec = 0;
  int last_wait;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_newline(inout int dw, inout int dr);
    ec = 0;
    if (er < ROWS - 1) er++;
    else begin
      for (int i = 0; i < CELLS - COLS; i++) em[i] = em[i + COLS];
      for (int i = CELLS - COLS; i < CELLS; i++) em[i] = BLANK;
      dr += CELLS - COLS;
      dw += CELLS;
    end
  endtask

  task automatic model_char(input logic [7:0] c, output int dw, output int dr);
    dw = 0; dr = 0;
    if (c == 8'h0C) begin
      for (int i = 0; i < CELLS; i++) em[i] = BLANK;
      dw = CELLS; er = 0; ec = 0;
    end else if (c == 8'h0D) begin
      model_newline(dw, dr);
    end else if (c == 8'h08) begin
      if (ec > 0 || er > 0) begin
        if (ec > 0) ec--;
        else begin er--; ec = COLS - 1; end
        em[er * COLS + ec] = BLANK;
        dw = 1;
      end
    end else begin
      em[er * COLS + ec] = c;
      dw = 1;
      ec++;
      if (ec == COLS) model_newline(dw, dr);
    end
  endtask

  task automatic wait_ready(input int budget, output int waited);
    waited = 0;
    while (!char_ready && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (!char_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic send_raw(input logic [7:0] c);
    int w;
    char_data = c;
    char_valid = 1'b1;
    w = 0;
    while (!char_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (!char_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic send_chk(input logic [7:0] c, input string tag);
    int bw, br, bo, dw, dr;
    bw = n_wr; br = n_rd; bo = n_ovl;
    send_raw(c);
    wait_ready(3000, last_wait);
    model_char(c, dw, dr);
    chk({tag, "_wr"}, n_wr - bw, dw);
    chk({tag, "_rd"}, n_rd - br, dr);
    chk({tag, "_ovl"}, n_ovl - bo, 0);
    chk({tag, "_row"}, int'(cursor_row), er);
    chk({tag, "_col"}, int'(cursor_col), ec);
  endtask

  task automatic chk_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < CELLS; i++) if (mem[i] !== em[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, int'(char_ready), 0);
    chk({tag, "_wr"}, int'(wr_ram1), 0);
    chk({tag, "_rd"}, int'(rd_ram1), 0);
    chk({tag, "_addr"}, int'(addr), 0);
    chk({tag, "_data"}, int'(data), 0);
    chk({tag, "_row"}, int'(cursor_row), 0);
    chk({tag, "_col"}, int'(cursor_col), 0);
  endtask

  task automatic release_and_check(input string tag);
    int bw, br, bq, w, bad;
    bw = n_wr; br = n_rd; bq = wq.size();
    @(negedge clk);
    resetn = 1'b1;
    wait_ready(2000, w);
    chk({tag, "_clr_wr"}, n_wr - bw, CELLS);
    chk({tag, "_clr_rd"}, n_rd - br, 0);
    bad = 0;
    for (int k = 0; k < CELLS; k++)
      if (bq + k >= wq.size() || wq[bq + k] != k) bad++;
    chk({tag, "_clr_seq"}, bad, 0);
    for (int i = 0; i < CELLS; i++) em[i] = BLANK;
    er = 0; ec = 0;
    chk_mem({tag, "_clr_mem"});
    chk({tag, "_ready"}, int'(char_ready), 1);
    chk({tag, "_row"}, int'(cursor_row), 0);
    chk({tag, "_col"}, int'(cursor_col), 0);
  endtask

  initial begin
    int bw, br, bo, dw, dr, tw, tr, w, r;
    logic [7:0] c;

    resetn = 1'b0;
    char_valid = 1'b0;
    char_data = 8'h00;
    preload_mode = 2'd1;
    @(negedge clk);
    @(negedge clk);
    preload_mode = 2'd0;
    chk_reset_outs("rst");
    release_and_check("init");

    // Single character, then backspace over it, then backspace at home
    send_chk(8'h41, "put_A");
    chk_mem("put_A_mem");
    send_chk(8'h08, "bs_01");
    send_chk(8'h08, "bs_00");
    chk("bs_00_ready_wait", last_wait, 0);

    for (int i = 0; i < COLS; i++) send_chk(8'h61 + 8'(i % 26), "row0");
    chk_mem("row0_mem");
    send_chk(8'h0D, "cr_to_2");
    send_chk(8'h08, "bs_20");
    chk("bs_20_addr", wq[wq.size() - 1], 63);
    chk_mem("bs_20_mem");

    // Full-screen scroll from (15,5) over a ramp pattern
    send_chk(8'h0C, "clr");
    for (int i = 0; i < ROWS - 1; i++) send_chk(8'h0D, "cr_down");
    for (int i = 0; i < 5; i++) send_chk(8'h30 + 8'(i), "row15");
    preload_mode = 2'd2;
    @(posedge clk);
    @(negedge clk);
    preload_mode = 2'd0;
    for (int i = 0; i < CELLS; i++) em[i] = 8'(i);
    bw = n_wr; br = n_rd;
    send_chk(8'h0D, "scroll");
    chk("scroll_strobes", (n_wr - bw) + (n_rd - br), 992);
    chk_mem("scroll_mem");

    // Source holds char_valid across busy cycles
    bw = n_wr; br = n_rd; bo = n_ovl; tw = 0; tr = 0;
    for (int i = 0; i < 6; i++) begin
      c = (i == 4) ? 8'h08 : 8'h4B + 8'(i);
      send_raw(c);
      model_char(c, dw, dr);
      tw += dw; tr += dr;
    end
    wait_ready(3000, w);
    chk("burst_wr", n_wr - bw, tw);
    chk("burst_rd", n_rd - br, tr);
    chk("burst_ovl", n_ovl - bo, 0);
    chk("burst_row", int'(cursor_row), er);
    chk("burst_col", int'(cursor_col), ec);
    chk_mem("burst_mem");

    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70) c = 8'(32'h21 + $urandom_range(0, 93));
      else if (r < 85) c = 8'h0D;
      else if (r < 97) c = 8'h08;
      else c = 8'h0C;
      send_chk(c, "rnd");
    end
    chk_mem("rnd_mem");

    // Reset asserted in the middle of a scroll
    send_chk(8'h0C, "pre_clr");
    for (int i = 0; i < ROWS - 1; i++) send_chk(8'h0D, "cr_abort");
    bw = n_wr; br = n_rd;
    char_data = 8'h0D;
    char_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    w = 0;
    while ((n_wr - bw) + (n_rd - br) < 300 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("abort_reached", (n_wr - bw) + (n_rd - br), 300);
    resetn = 1'b0;
    #1;
    chk_reset_outs("abort");
    @(negedge clk);
    @(negedge clk);
    release_and_check("after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/text_console.md
TEXT_CONSOLE -- requirements
Module: text_console

Interface
REQ-001 Parameter COLS, default 32, meaning characters per text row (power of two).
REQ-002 Parameter ROWS, default 16, meaning text rows on screen.
REQ-003 Parameter BLANK, default 8'h20, meaning fill code used for clear, scroll and erase.
REQ-004 Port clk  input  1  single clock; every register is clocked on its rising edge.
REQ-005 Port resetn  input  1  asynchronous, active-low reset.
REQ-006 Port char_valid  input  1  character offered on char_data.
REQ-007 Port char_data  input  8  character code or control code.
REQ-008 Port char_ready  output  1  high when the block can accept a character.
REQ-009 Port wr_ram1  output  1  video RAM write strobe.
REQ-010 Port rd_ram1  output  1  video RAM read strobe.
REQ-011 Port addr  output  11  video RAM address.
REQ-012 Port data  output  8  video RAM write data.
REQ-013 Port ram1_out  input  8  video RAM read data, valid in the cycle after the cycle in which rd_ram1 is high.
REQ-014 Port cursor_row  output  4  current cursor row.
REQ-015 Port cursor_col  output  5  current cursor column.

Function
REQ-016 Video RAM layout SHALL be addr = cursor_row*COLS + cursor_col; addr[10:9] SHALL always be 0 for the default parameters.
REQ-017 FSM states SHALL be IDLE, PUT, SCROLL_RD, SCROLL_WR, SCROLL_CLR and CLEAR.
REQ-018 char_ready SHALL be high only in IDLE; a character is accepted on a cycle where char_valid and char_ready are both high.
REQ-019 rd_ram1 and wr_ram1 SHALL never be high in the same cycle; both SHALL be low in IDLE.
REQ-020 Code 8'h0C SHALL enter CLEAR: COLS*ROWS consecutive write cycles, addr 0 up to COLS*ROWS-1, data BLANK; then cursor goes to (0,0) and the FSM returns to IDLE.
REQ-021 Code 8'h0D SHALL set cursor_col to 0; if cursor_row < ROWS-1, cursor_row increments and the FSM stays in IDLE; otherwise the FSM enters SCROLL_RD with cursor_row held at ROWS-1.
REQ-022 Code 8'h08 at column > 0 SHALL decrement cursor_col; at (row > 0, col 0) it SHALL move to (row-1, COLS-1); in both cases a single write cycle of BLANK follows at the new position.
REQ-023 Code 8'h08 at (0,0) SHALL do nothing: no write, cursor unchanged, char_ready high on the next cycle.
REQ-024 Any other code SHALL enter PUT: one write cycle with addr = current cursor and data = char_data, then the cursor advances.
REQ-025 Cursor advance: cursor_col increments; on wrap from COLS-1 to 0, the row advances under the rules of REQ-021, including the scroll at the last row.
REQ-026 Scroll, copy phase: for i = 0 to (ROWS-1)*COLS-1, one SCROLL_RD cycle (rd_ram1 high, addr = i+COLS) is followed by one SCROLL_WR cycle (wr_ram1 high, addr = i, data = the ram1_out value from that read).
REQ-027 Scroll, clear phase: SCROLL_CLR then writes BLANK to addr (ROWS-1)*COLS up to ROWS*COLS-1, one per cycle, and returns to IDLE.
REQ-028 Scroll with default parameters SHALL take exactly 992 strobe cycles (480 reads, 480 copy writes, 32 blank writes).
REQ-029 Characters offered while char_ready is low SHALL be neither lost nor double-accepted; char_valid is held by the source until accepted.

Reset
REQ-030 While resetn is low: char_ready=0, wr_ram1=0, rd_ram1=0, addr=0, data=0, cursor_row=0, cursor_col=0; this takes effect immediately, without waiting for a clock edge.
REQ-031 On resetn release the FSM SHALL enter CLEAR (REQ-020) before the first IDLE.
REQ-032 Reset asserted mid-scroll or mid-clear SHALL abort the operation at once; the next release restarts with a full CLEAR.

Verification
REQ-033 Reset release -> 512 write cycles, addr 0..511, data 8'h20, no reads; then char_ready=1 with cursor (0,0).
REQ-034 After init, send 8'h41 -> exactly one write at addr 0 with data 8'h41; cursor becomes (0,1).
REQ-035 Send 32 printable characters from (0,0) -> writes at addr 0..31; cursor becomes (1,0); no scroll occurs.
REQ-036 Preload the RAM model with addr i = i[7:0], set cursor to (15,5), send 8'h0D -> 992 strobe cycles; RAM addr 0..479 then holds the old values of addr 32..511 and addr 480..511 hold 8'h20; cursor (15,0); rd_ram1 and wr_ram1 never overlap.
REQ-037 Backspace tests: 8'h08 at (0,0) -> no strobe, cursor stays (0,0); 8'h08 at (2,0) -> one write at addr 63 with data 8'h20, cursor (1,31).
REQ-038 Assert resetn low during scroll cycle 300 -> all strobes drop low at once; after release a full 512-cycle CLEAR runs, then cursor is (0,0).
